mod_updown_counter: RTL and testbench

- Parametrised successor to the single-channel free-running enable counter.
- Adds modulus, direction control, parallel load, synchronous clear and three end-of-count modes: wrap, saturate and one-shot.
- Generates a registered wrap/terminal event pulse.
- Sits in the same testbench-driven environment, connected through an interface carrying clk/reset plus control signals.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/counter_next_val.sv | 53 +++++
 rtl/mod_updown_counter.sv | 123 ++++++++++++
 tb/tb_mod_updown_counter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo up/down counter.
// Mode and FSM encodings plus the terminal-value helper.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  function automatic int term_val(
    input logic up,
    input int   m
  );
    return up ? m - 1 : 0;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-count for the modulo up/down counter.
// Flags the terminal step and whether the mode holds there.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_dn_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             at_term_o,
  output logic             hold_o
);

  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MOD - 1);

  mode_e          md;
  logic [WIDTH:0] cnt_w;
  logic [WIDTH:0] term_w;
  logic [WIDTH:0] step_w;

  assign md     = mode_e'(mode_i);
  assign cnt_w  = {1'b0, count_i};
  assign term_w = (WIDTH+1)'(term_val(up_dn_i, MOD));

  assign at_term_o = (cnt_w == term_w);
  assign hold_o    = at_term_o &&
                     (md == MODE_SAT || md == MODE_ONESHOT);

  always_comb begin
    step_w = cnt_w;
    if (at_term_o) begin
      step_w = up_dn_i ? '0 : MAX_W;
    end else if (up_dn_i) begin
      step_w = cnt_w + 1'b1;
    end else begin
      step_w = cnt_w - 1'b1;
    end
  end

  // clamp keeps the result inside 0..MOD-1 even on bad input
  always_comb begin
    next_o = step_w[WIDTH-1:0];
    if (hold_o) begin
      next_o = count_i;
    end else if (step_w > MAX_W) begin
      next_o = MAX_W[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with load, clear and end-of-count modes.
// Registers, one-shot FSM and the reset>clear>load>en priority mux.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MOD     = 2 ** WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err,
  output logic             done
);

  if (MOD < 2 || MOD > 2 ** WIDTH ||
      RST_VAL < 0 || RST_VAL >= MOD) begin : g_bad_param
    $error("mod_updown_counter: illegal MOD/RST_VAL");
  end

  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  state_e           st_q, st_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;
  logic             blk_q, blk_d;

  logic [WIDTH-1:0] nxt;
  logic             at_term;
  logic             hold;
  mode_e            md;

  assign md = mode_e'(mode);

  counter_next_val #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .count_i   (cnt_q),
    .up_dn_i   (up_dn),
    .mode_i    (mode),
    .next_o    (nxt),
    .at_term_o (at_term),
    .hold_o    (hold)
  );

  always_comb begin
    cnt_d  = cnt_q;
    st_d   = st_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    blk_d  = blk_q;
    if (clear) begin
      cnt_d = RST_C;
      st_d  = ST_RUN;
      blk_d = 1'b0;
    end else if (load) begin
      if ({1'b0, load_val} >= MOD_W) begin
        cnt_d  = MAX_C;
        lerr_d = 1'b1;
      end else begin
        cnt_d = load_val;
      end
      st_d  = ST_RUN;
      blk_d = 1'b0;
    end else if (en && st_q == ST_RUN) begin
      cnt_d = nxt;
      blk_d = 1'b0;
      if (at_term) begin
        // blk_q remembers a saturated hold so wrap fires only once
        unique case (md)
          MODE_SAT: begin
            wrap_d = !blk_q;
            blk_d  = 1'b1;
          end
          MODE_ONESHOT: begin
            wrap_d = 1'b1;
            st_d   = ST_DONE;
          end
          default: wrap_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= RST_C;
      st_q   <= ST_RUN;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
      blk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
      blk_q  <= blk_d;
    end
  end

  assign count_out = cnt_q;
  assign tc        = (cnt_q == WIDTH'(term_val(up_dn, MOD)));
  assign wrap      = wrap_q;
  assign load_err  = lerr_q;
  assign done      = (st_q == ST_DONE);

  logic unused_hold;
  assign unused_hold = hold;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed vector table, a few
// hand sequences, then random stimulus against a modular model.
module tb_mod_updown_counter;

  localparam int W   = 4;
  localparam int MOD = 10;
  localparam int RST = 0;

  logic         clk = 1'b0;
  logic         reset, en, up_dn, clear, load;
  logic [1:0]   mode;
  logic [W-1:0] load_val;
  logic [W-1:0] count_out;
  logic         tc, wrap, load_err, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(
    .WIDTH   (W),
    .MOD     (MOD),
    .RST_VAL (RST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .up_dn     (up_dn),
    .mode      (mode),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .count_out (count_out),
    .tc        (tc),
    .wrap      (wrap),
    .load_err  (load_err),
    .done      (done)
  );

  typedef struct {
    logic       rst, en, up;
    logic [1:0] md;
    logic       clr, ld;
    logic [3:0] lv;
    int         cnt;
    logic       w, le, dn;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic rst, input logic e, input logic up,
    input int md, input logic clr, input logic ld,
    input int lv, input int cnt,
    input logic w, input logic le, input logic dn
  );
    vec_t v;
    v.rst = rst; v.en = e; v.up = up;
    v.md  = 2'(md); v.clr = clr; v.ld = ld;
    v.lv  = 4'(lv); v.cnt = cnt;
    v.w   = w; v.le = le; v.dn = dn;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: plain modular arithmetic on integers
  int m_cnt;
  bit m_dn, m_held, m_w, m_le;

  task automatic model_step();
    int term;
    m_w  = 0;
    m_le = 0;
    if (reset || clear) begin
      m_cnt = RST; m_dn = 0; m_held = 0;
    end else if (load) begin
      if (int'(load_val) >= MOD) begin
        m_cnt = MOD - 1; m_le = 1;
      end else begin
        m_cnt = int'(load_val);
      end
      m_dn = 0; m_held = 0;
    end else if (en && !m_dn) begin
      term = up_dn ? MOD - 1 : 0;
      if (m_cnt != term) begin
        m_cnt  = (m_cnt + (up_dn ? 1 : MOD - 1)) % MOD;
        m_held = 0;
      end else if (mode == 2'd1) begin
        m_w = !m_held; m_held = 1;
      end else if (mode == 2'd2) begin
        m_w = 1; m_dn = 1;
      end else begin
        m_cnt  = (m_cnt + (up_dn ? 1 : MOD - 1)) % MOD;
        m_w    = 1;
        m_held = 0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; mode = 2'd0;
    clear = 1'b0; load = 1'b0; load_val = '0;

    // count up through wrap
    tv.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0));
    for (int i = 1; i <= 11; i++)
      tv.push_back(mk(0,1,1,0,0,0,0, i % 10, i == 10, 0, 0));
    // count down from reset
    tv.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,0,0,0,0,0, 9,1,0,0));
    tv.push_back(mk(0,1,0,0,0,0,0, 8,0,0,0));
    // saturate up, then down, then flip
    tv.push_back(mk(0,1,1,1,0,1,8, 8,0,0,0));
    tv.push_back(mk(0,1,1,1,0,0,0, 9,0,0,0));
    tv.push_back(mk(0,1,1,1,0,0,0, 9,1,0,0));
    tv.push_back(mk(0,1,1,1,0,0,0, 9,0,0,0));
    tv.push_back(mk(0,1,1,1,0,0,0, 9,0,0,0));
    tv.push_back(mk(0,0,1,1,0,0,0, 9,0,0,0));
    tv.push_back(mk(0,1,1,1,0,0,0, 9,0,0,0));
    tv.push_back(mk(0,0,0,1,0,1,1, 1,0,0,0));
    tv.push_back(mk(0,1,0,1,0,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,0,1,0,0,0, 0,1,0,0));
    tv.push_back(mk(0,1,0,1,0,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,1,1,0,0,0, 1,0,0,0));
    // one-shot
    tv.push_back(mk(0,0,1,2,0,1,7, 7,0,0,0));
    tv.push_back(mk(0,1,1,2,0,0,0, 8,0,0,0));
    tv.push_back(mk(0,1,1,2,0,0,0, 9,0,0,0));
    tv.push_back(mk(0,1,1,2,0,0,0, 9,1,0,1));
    tv.push_back(mk(0,1,1,2,0,0,0, 9,0,0,1));
    tv.push_back(mk(0,1,1,0,0,0,0, 9,0,0,1));
    tv.push_back(mk(0,1,0,0,0,0,0, 9,0,0,1));
    tv.push_back(mk(0,1,1,2,0,1,3, 3,0,0,0));
    tv.push_back(mk(0,1,1,2,0,0,0, 4,0,0,0));
    tv.push_back(mk(0,0,1,2,0,1,9, 9,0,0,0));
    tv.push_back(mk(0,1,1,2,0,0,0, 9,1,0,1));
    tv.push_back(mk(0,1,1,2,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,0,2,0,0,0, 0,1,0,1));
    tv.push_back(mk(0,0,0,2,1,0,0, 0,0,0,0));
    // load range and priority
    tv.push_back(mk(0,0,1,0,0,1,12, 9,0,1,0));
    tv.push_back(mk(0,0,1,0,0,0,0,  9,0,0,0));
    tv.push_back(mk(0,0,1,0,1,1,12, 0,0,0,0));
    tv.push_back(mk(0,0,1,0,0,1,10, 9,0,1,0));
    tv.push_back(mk(0,0,1,0,0,1,15, 9,0,1,0));
    tv.push_back(mk(0,0,1,0,0,1,9,  9,0,0,0));
    tv.push_back(mk(0,1,1,0,1,0,0,  0,0,0,0));
    tv.push_back(mk(0,1,1,0,0,1,9,  9,0,0,0));
    tv.push_back(mk(0,1,1,0,0,1,5,  5,0,0,0));
    tv.push_back(mk(0,0,1,3,0,1,9,  9,0,0,0));
    tv.push_back(mk(0,1,1,3,0,0,0,  0,1,0,0));
    // reset mid-count, in DONE, over a wrap and a bad load
    tv.push_back(mk(0,0,1,0,0,1,5,  5,0,0,0));
    tv.push_back(mk(1,1,1,0,0,0,0,  0,0,0,0));
    tv.push_back(mk(0,0,1,2,0,1,9,  9,0,0,0));
    tv.push_back(mk(0,1,1,2,0,0,0,  9,1,0,1));
    tv.push_back(mk(1,1,1,2,0,0,0,  0,0,0,0));
    tv.push_back(mk(0,1,1,2,0,0,0,  1,0,0,0));
    tv.push_back(mk(0,0,1,0,0,1,9,  9,0,0,0));
    tv.push_back(mk(1,1,1,0,0,0,0,  0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,1,12, 0,0,0,0));

    @(negedge clk);
    foreach (tv[i]) begin
      reset = tv[i].rst; en = tv[i].en; up_dn = tv[i].up;
      mode = tv[i].md; clear = tv[i].clr; load = tv[i].ld;
      load_val = tv[i].lv;
      @(posedge clk); #1;
      chk($sformatf("v%0d cnt", i), 32'(count_out), 32'(tv[i].cnt));
      chk($sformatf("v%0d tc", i), 32'(tc),
          32'(tv[i].cnt == (tv[i].up ? MOD - 1 : 0)));
      chk($sformatf("v%0d wrap", i), 32'(wrap), 32'(tv[i].w));
      chk($sformatf("v%0d lerr", i), 32'(load_err), 32'(tv[i].le));
      chk($sformatf("v%0d done", i), 32'(done), 32'(tv[i].dn));
      @(negedge clk);
    end

    // tc follows up_dn with no clock edge in between
    reset = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b1;
    load_val = 4'd9;
    @(posedge clk); #1;
    @(negedge clk);
    load = 1'b0; up_dn = 1'b1; #1;
    chk("tc up at 9", 32'(tc), 32'd1);
    up_dn = 1'b0; #1;
    chk("tc dn at 9", 32'(tc), 32'd0);
    clear = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    clear = 1'b0; #1;
    chk("tc dn at 0", 32'(tc), 32'd1);
    up_dn = 1'b1; #1;
    chk("tc up at 0", 32'(tc), 32'd0);

    // random phase against the model
    for (int c = 0; c < 3000; c++) begin
      reset    = (c == 0) || ($urandom_range(0, 63) == 0);
      clear    = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      model_step();
      @(posedge clk); #1;
      chk($sformatf("r%0d cnt", c), 32'(count_out), 32'(m_cnt));
      chk($sformatf("r%0d tc", c), 32'(tc),
          32'(m_cnt == (up_dn ? MOD - 1 : 0)));
      chk($sformatf("r%0d wrap", c), 32'(wrap), 32'(m_w));
      chk($sformatf("r%0d lerr", c), 32'(load_err), 32'(m_le));
      chk($sformatf("r%0d done", c), 32'(done), 32'(m_dn));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
